// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/GEMM memory bus arbiter: FSM state and port IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CPU  = 2'd1,
        BUSY_GEMM = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_GEMM = 1'b1;

    function automatic arb_state_t busy_state(input logic port);
        return (port == PORT_GEMM) ? BUSY_GEMM : BUSY_CPU;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating transaction timeout counter; expired is high once the count reaches TIMEOUT_CYCLES-1.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == Limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a GEMM DMA engine,
// with a per-transaction timeout that completes the request with an error flag.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_rd_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_mask,
    output logic        cpu_valid,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        gemm_req,
    input  logic        gemm_rd_wr,
    input  logic [31:0] gemm_addr,
    input  logic [31:0] gemm_wdata,
    input  logic [3:0]  gemm_mask,
    output logic        gemm_valid,
    output logic        gemm_err,
    output logic [31:0] gemm_rdata,
    output logic        cs,
    output logic        mem_rd_wr,
    output logic [3:0]  mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid
);

    arb_state_t  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        cs_q, cs_d;
    logic        rd_wr_q, rd_wr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        busy, expired, done, timeout, grant_port;
    logic [31:0] resp_rdata;

    assign busy    = (state_q != IDLE);
    assign done    = busy && (mem_valid || expired);
    // A response arriving on the expiry cycle wins over the timeout.
    assign timeout = busy && expired && !mem_valid;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!busy),
        .enable (busy && !mem_valid),
        .expired(expired)
    );

    always_comb begin
        if (cpu_req && gemm_req) begin
            grant_port = ~last_grant_q;
        end else if (gemm_req) begin
            grant_port = PORT_GEMM;
        end else begin
            grant_port = PORT_CPU;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cs_d         = cs_q;
        rd_wr_d      = rd_wr_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || gemm_req) begin
                    state_d      = busy_state(grant_port);
                    last_grant_d = grant_port;
                    cs_d         = 1'b1;
                    rd_wr_d      = (grant_port == PORT_GEMM) ? gemm_rd_wr : cpu_rd_wr;
                    mask_d       = (grant_port == PORT_GEMM) ? gemm_mask  : cpu_mask;
                    addr_d       = (grant_port == PORT_GEMM) ? gemm_addr  : cpu_addr;
                    wdata_d      = (grant_port == PORT_GEMM) ? gemm_wdata : cpu_wdata;
                end
            end
            BUSY_CPU, BUSY_GEMM: begin
                if (done) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_GEMM;
            cs_q         <= 1'b0;
            rd_wr_q      <= 1'b0;
            mask_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cs_q         <= cs_d;
            rd_wr_q      <= rd_wr_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign resp_rdata = (mem_valid && rd_wr_q) ? mem_read_data : 32'h0;

    always_comb begin
        cpu_valid  = (state_q == BUSY_CPU) && done;
        gemm_valid = (state_q == BUSY_GEMM) && done;
        cpu_err    = cpu_valid && timeout;
        gemm_err   = gemm_valid && timeout;
        cpu_rdata  = cpu_valid ? resp_rdata : 32'h0;
        gemm_rdata = gemm_valid ? resp_rdata : 32'h0;
    end

    assign cs             = cs_q;
    assign mem_rd_wr      = rd_wr_q;
    assign mask           = mask_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: stimulus queues expected completions,
// a negedge monitor pops and compares them whenever a port reports valid.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_rd_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_mask = '0;
    logic        cpu_valid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        gemm_req = 1'b0, gemm_rd_wr = 1'b0;
    logic [31:0] gemm_addr = '0, gemm_wdata = '0;
    logic [3:0]  gemm_mask = '0;
    logic        gemm_valid, gemm_err;
    logic [31:0] gemm_rdata;
    logic        cs, mem_rd_wr;
    logic [3:0]  mask;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        mem_valid = 1'b0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_rd_wr     (cpu_rd_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_mask      (cpu_mask),
        .cpu_valid     (cpu_valid),
        .cpu_err       (cpu_err),
        .cpu_rdata     (cpu_rdata),
        .gemm_req      (gemm_req),
        .gemm_rd_wr    (gemm_rd_wr),
        .gemm_addr     (gemm_addr),
        .gemm_wdata    (gemm_wdata),
        .gemm_mask     (gemm_mask),
        .gemm_valid    (gemm_valid),
        .gemm_err      (gemm_err),
        .gemm_rdata    (gemm_rdata),
        .cs            (cs),
        .mem_rd_wr     (mem_rd_wr),
        .mask          (mask),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_valid     (mem_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_valid || gemm_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got cpu=%0b gemm=%0b, expected none (t=%0t)",
                             cpu_valid, gemm_valid, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("both_valid", 32'(cpu_valid & gemm_valid), 32'h0);
                    check("valid_port", 32'(gemm_valid), 32'(mon_e.port));
                    if (mon_e.port) begin
                        check("gemm_err", 32'(gemm_err), 32'(mon_e.err));
                        check("gemm_rdata", gemm_rdata, mon_e.rdata);
                        check("cpu_side_quiet", {31'h0, cpu_err} | cpu_rdata, 32'h0);
                    end else begin
                        check("cpu_err", 32'(cpu_err), 32'(mon_e.err));
                        check("cpu_rdata", cpu_rdata, mon_e.rdata);
                        check("gemm_side_quiet", {31'h0, gemm_err} | gemm_rdata, 32'h0);
                    end
                end
            end else begin
                check("idle_quiet", {30'h0, cpu_err, gemm_err} | cpu_rdata | gemm_rdata, 32'h0);
            end
        end
    end

    task automatic do_txn(input logic port, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] msk, input int lat,
                          input logic [31:0] mdata, input logic exp_err, input int exp_cs,
                          input string name);
        exp_t e;
        int   n_cs;
        logic stable;
        logic seen;
        e.port  = port;
        e.err   = exp_err;
        e.rdata = (rd && !exp_err) ? mdata : 32'h0;
        exp_q.push_back(e);
        if (port) begin
            gemm_req = 1'b1; gemm_rd_wr = rd; gemm_addr = addr; gemm_wdata = wdata;
            gemm_mask = msk;
        end else begin
            cpu_req = 1'b1; cpu_rd_wr = rd; cpu_addr = addr; cpu_wdata = wdata;
            cpu_mask = msk;
        end
        mem_read_data = (lat < 0) ? mdata : 32'h0;
        @(posedge clk); #1;
        n_cs = 0;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (lat >= 0 && k == lat + 1) begin
                mem_valid = 1'b1;
                mem_read_data = mdata;
            end
            @(negedge clk);
            if (!cs) break;
            n_cs++;
            if (mem_rd_wr !== rd || mem_addr !== addr || mem_write_data !== wdata ||
                mask !== msk) stable = 1'b0;
            seen = cpu_valid | gemm_valid;
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (lat >= 0) mem_read_data = 32'h0;
            if (seen) begin
                cpu_req = 1'b0;
                gemm_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        gemm_req = 1'b0;
        mem_read_data = 32'h0;
        check({name, "_cs_cycles"}, 32'(n_cs), 32'(exp_cs));
        check({name, "_fields_stable"}, 32'(stable), 32'h1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100us");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state.
        #3;
        check("rst_cs", 32'(cs), 32'h0);
        check("rst_mem_fields", {31'h0, mem_rd_wr} | {28'h0, mask} | mem_addr | mem_write_data,
              32'h0);
        check("rst_valids", {30'h0, cpu_valid, gemm_valid}, 32'h0);
        apply_reset();

        // CPU read, response in the third cs cycle.
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, 3, "cpu_read");

        // GEMM write with all fields checked across the cs window.
        do_txn(1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 4'hF, 1, 32'h0, 1'b0, 2, "gemm_write");

        // Timeout: no response, error in the 8th busy cycle, rdata forced to zero.
        do_txn(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h3, -1, 32'hBAD0_BAD0, 1'b1, 8, "timeout");

        // Response landing exactly on the expiry cycle completes normally.
        do_txn(1'b1, 1'b1, 32'h0000_0030, 32'h0, 4'h1, 7, 32'hC0DE_0007, 1'b0, 8, "late_ok");

        // Round-robin with both requests held across four transactions.
        apply_reset();
        cpu_req = 1'b1; cpu_rd_wr = 1'b1; cpu_addr = 32'h0000_0100;
        gemm_req = 1'b1; gemm_rd_wr = 1'b1; gemm_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{port: i[0], err: 1'b0, rdata: 32'hA000_0000 + 32'(i)});
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("rr_grant_%0d", i), mem_addr,
                  i[0] ? 32'h0000_0200 : 32'h0000_0100);
            @(posedge clk); #1;
            mem_valid = 1'b1;
            mem_read_data = 32'hA000_0000 + 32'(i);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            mem_read_data = 32'h0;
        end
        cpu_req = 1'b0;
        gemm_req = 1'b0;
        @(negedge clk);

        // Reset in the second busy cycle of a CPU transaction.
        cpu_req = 1'b1; cpu_rd_wr = 1'b1; cpu_addr = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_cs_drop", 32'(cs), 32'h0);
        check("midrst_no_valid", {30'h0, cpu_valid, gemm_valid}, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First tie after reset goes to the CPU, then the held GEMM request is served.
        cpu_req = 1'b1; cpu_addr = 32'h0000_0400; cpu_rd_wr = 1'b1;
        gemm_req = 1'b1; gemm_addr = 32'h0000_0500; gemm_rd_wr = 1'b1;
        exp_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0000_0077});
        exp_q.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0000_0088});
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_tie", mem_addr, 32'h0000_0400);
        mem_valid = 1'b1;
        mem_read_data = 32'h0000_0077;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_gemm", mem_addr, 32'h0000_0500);
        mem_valid = 1'b1;
        mem_read_data = 32'h0000_0088;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        gemm_req = 1'b0;
        mem_read_data = 32'h0;

        // mem_valid while idle must not produce a completion.
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_read_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("idle_memvalid_%0d", i), {30'h0, cpu_valid, gemm_valid}, 32'h0);
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        mem_read_data = 32'h0;

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
